regfile_mp: RTL

//  Parametrised multi-port integer register file; successor to the 2R/1W core register file.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_clear_fsm.sv | 66 ++++++
 rtl/regfile_mp.sv | 74 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

  // Address width for a register file of nregs entries (nregs is a power of 2).
  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read port bundle of the register file, plus clear request and ready.
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  localparam int AW = regfile_pkg::rf_aw(NREGS);

  logic                             clear_req;
  logic                             ready;
  logic [NUM_WR-1:0]                wen;
  logic [NUM_WR-1:0][AW-1:0]        waddr;
  logic [NUM_WR-1:0][XLEN-1:0]      wdata;
  logic [NUM_RD-1:0]                ren;
  logic [NUM_RD-1:0][AW-1:0]        raddr;
  logic [NUM_RD-1:0][XLEN-1:0]      rdata;

  modport master (
    output clear_req, wen, waddr, wdata, ren, raddr,
    input  ready, rdata
  );

  modport slave (
    input  clear_req, wen, waddr, wdata, ren, raddr,
    output ready, rdata
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: zeroes one entry per cycle after reset or on request,
// then reports the array as ready.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  RF_CLEAR | writing 0 to entry clr_idx each cycle; array not usable
//  RF_READY | array valid; normal reads/writes; clear_req restarts clear
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // State and index registers; reset always restarts the clear from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; clear_req is only honoured once the array is ready.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = RF_READY;
          idx_d   = '0;
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  assign ready   = (state_q == RF_READY);
  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads, write-to-read
// bypass and a hardware clear sequencer (the array itself has no reset).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int AW = rf_aw(NREGS);

  logic          ready;
  logic          clr_we;
  logic [AW-1:0] clr_idx;
  logic [XLEN-1:0] mem_q [NREGS];

  regfile_clear_fsm #(.NREGS(NREGS)) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (bus.clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  assign bus.ready = ready;

  // Array update: clear has precedence; later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else if (ready) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wen[i] && !((ZERO_REG != 0) && (bus.waddr[i] == '0)))
          mem_q[bus.waddr[i]] <= bus.wdata[i];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [XLEN-1:0] rd_d, rd_q;

    // Read value with bypass from same-cycle writes; entry 0 reads as 0.
    always_comb begin
      rd_d = mem_q[bus.raddr[j]];
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wen[i] && (bus.waddr[i] == bus.raddr[j]))
          rd_d = bus.wdata[i];
      end
      if ((ZERO_REG != 0) && (bus.raddr[j] == '0))
        rd_d = '0;
    end

    // Registered read port; held at 0 while clearing, holds when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        rd_q <= '0;
      else if (!ready)
        rd_q <= '0;
      else if (bus.ren[j])
        rd_q <= rd_d;
    end

    assign bus.rdata[j] = rd_q;
  end

endmodule
